sram_like_arbiter: RTL

Two-to-one arbiter that shares the single SRAM-like master port of the AXI interface between the instruction cache (miss refills) and the data cache (miss refills and write-throughs). It sits between the two caches' `cache_*` ports and the AXI bridge. It grants one requester at a time and latches that requester's command. It forwards it to the bridge and returns `addr_ok`/`data_ok` only to the owner. Exactly one transaction is outstanding at any time.

---
 rtl/sram_like_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/sram_like_arbiter.sv
// Two-to-one arbiter sharing one SRAM-like bridge port between the I-cache and the D-cache.
// Define ARB_RR_EN for round-robin arbitration; fixed data-first priority otherwise.
module sram_like_arbiter #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              i_req,
   input  logic              i_wr,
   input  logic [1:0]        i_size,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_addr_ok,
   output logic              i_data_ok,
   input  logic              d_req,
   input  logic              d_wr,
   input  logic [1:0]        d_size,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_addr_ok,
   output logic              d_data_ok,
   output logic              m_req,
   output logic              m_wr,
   output logic [1:0]        m_size,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   input  logic [DATA_W-1:0] m_rdata,
   input  logic              m_addr_ok,
   input  logic              m_data_ok
);

   typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

   state_e              state_q;
   logic                owner_q;
   logic                m_req_q;
   logic                cmd_wr_q;
   logic [1:0]          cmd_size_q;
   logic [ADDR_W-1:0]   cmd_addr_q;
   logic [DATA_W-1:0]   cmd_wdata_q;
   logic                grant;
   logic                addr_ok_fwd;
   logic                data_ok_fwd;

`ifdef ARB_RR_EN
   logic last_q;

   // On contention, serve whichever port was not granted last.
   always_comb begin
      grant = d_req;
      if (i_req && d_req) begin
         grant = ~last_q;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         last_q <= 1'b1;
      end else if (state_q == StIdle && (i_req || d_req)) begin
         last_q <= grant;
      end
   end
`else
   assign grant = d_req;
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= StIdle;
         owner_q     <= 1'b0;
         m_req_q     <= 1'b0;
         cmd_wr_q    <= 1'b0;
         cmd_size_q  <= 2'd0;
         cmd_addr_q  <= '0;
         cmd_wdata_q <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (i_req || d_req) begin
                  owner_q     <= grant;
                  m_req_q     <= 1'b1;
                  cmd_wr_q    <= grant ? d_wr    : i_wr;
                  cmd_size_q  <= grant ? d_size  : i_size;
                  cmd_addr_q  <= grant ? d_addr  : i_addr;
                  cmd_wdata_q <= grant ? d_wdata : i_wdata;
                  state_q     <= StAddr;
               end
            end
            StAddr: begin
               if (m_addr_ok) begin
                  m_req_q <= 1'b0;
                  state_q <= m_data_ok ? StIdle : StData;
               end
            end
            StData: begin
               if (m_data_ok) begin
                  state_q <= StIdle;
               end
            end
            default: begin
               m_req_q <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

   // Bridge handshakes only reach the owner, and only in the matching phase.
   assign addr_ok_fwd = (state_q == StAddr) && m_addr_ok;
   assign data_ok_fwd = m_data_ok && ((state_q == StData) || addr_ok_fwd);

   assign i_addr_ok = addr_ok_fwd && !owner_q;
   assign d_addr_ok = addr_ok_fwd && owner_q;
   assign i_data_ok = data_ok_fwd && !owner_q;
   assign d_data_ok = data_ok_fwd && owner_q;

   assign i_rdata = m_rdata;
   assign d_rdata = m_rdata;

   assign m_req   = m_req_q;
   assign m_wr    = cmd_wr_q;
   assign m_size  = cmd_size_q;
   assign m_addr  = cmd_addr_q;
   assign m_wdata = cmd_wdata_q;

endmodule
